// File: rtl/lrf_pkg.sv
// Shared types and helpers for the LRF frame sequencer: FSM states, per-beat
// tag bundle carried alongside memory reads, and width/LFSR constants.
package lrf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FLUSH,
        DRAIN
    } seq_state_t;

    typedef struct packed {
        logic zero;
        logic tlast;
        logic tuser;
    } beat_tag_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lrf_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two; push and pop on a full FIFO in one cycle is legal.
module lrf_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lrf_frame_sequencer.sv
// AXI4-Stream NEW/OLD frame-pair source for the LRF fusion core.
// Optional macro LRF_SEQ_THROTTLE_EN gates tvalid rises with a 16-bit LFSR.
module lrf_frame_sequencer
    import lrf_pkg::*;
#(
    parameter int unsigned PIXELS_PER_BEAT = 16,
    parameter int unsigned PIXEL_WIDTH     = 8,
    parameter int unsigned IMAGE_DIM       = 512,
    parameter int unsigned MAX_IMAGES      = 64,
    parameter int unsigned N_FUSE_COUNT    = 4,
    parameter int unsigned PIPELINE_DELAY  = 10,
    parameter int unsigned MEM_LATENCY     = 2,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned ADDR_W          = 32
) (
    input  logic                                    s_axis_aclk,
    input  logic                                    s_axis_areset,
    input  logic                                    start,
    input  logic [$clog2(MAX_IMAGES+1)-1:0]         cfg_n_images,
    input  logic [ADDR_W-1:0]                       cfg_base_addr,
    input  logic                                    cfg_old_zero,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    mem_rd_en,
    output logic [ADDR_W-1:0]                       mem_rd_addr,
    input  logic [PIXELS_PER_BEAT*PIXEL_WIDTH-1:0]  mem_rd_data,
    output logic [PIXELS_PER_BEAT*PIXEL_WIDTH-1:0]  m_axis_tdata,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic                                    m_axis_tlast,
    output logic                                    m_axis_tuser
);

    localparam int unsigned WORD_W = PIXELS_PER_BEAT * PIXEL_WIDTH;
    localparam int unsigned WPI    = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int unsigned H      = 1 << N_FUSE_COUNT;
    localparam int unsigned NW     = $clog2(MAX_IMAGES + 1);
    localparam int unsigned BW     = width_of(WPI);
    localparam int unsigned PW     = width_of(2 * MAX_IMAGES);
    localparam int unsigned FW     = width_of(PIPELINE_DELAY + 1);
    localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IW     = $clog2(MEM_LATENCY + 1);

    seq_state_t        state, state_n;
    logic [NW-1:0]     n_q;
    logic [ADDR_W-1:0] base_q;
    logic              old_zero_q;
    logic [PW-1:0]     frame;
    logic [BW-1:0]     beat;
    logic [FW-1:0]     flush_cnt;
    logic              done_q;
    logic              drain_done;

    logic [PW-1:0]     k;
    logic [PW-1:0]     img;
    logic              old_early;
    logic              beat_last;
    logic              seq_last;
    logic              has_credit;
    logic              issue;
    beat_tag_t         issue_tag;

    logic              pipe_v   [MEM_LATENCY];
    beat_tag_t         pipe_tag [MEM_LATENCY];
    logic [IW-1:0]     inflight;

    logic [WORD_W+1:0] fifo_din;
    logic [WORD_W+1:0] fifo_dout;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              pop;

    // Source image of the frame being issued; early OLD frames fall back to image 0.
    always_comb begin
        k         = frame >> 1;
        old_early = 32'(k) < H;
        if (!frame[0])      img = k;
        else if (!old_early) img = k - PW'(H);
        else                 img = '0;
    end

    assign beat_last  = (beat == BW'(WPI - 1));
    assign seq_last   = 32'(frame) == ((32'(n_q) << 1) - 32'd1);
    assign has_credit = (32'(inflight) + 32'(fifo_count)) < FIFO_DEPTH;
    assign issue      = ((state == ISSUE) || (state == FLUSH)) && has_credit;

    always_comb begin
        issue_tag.zero  = (state == FLUSH) || (frame[0] && old_early && old_zero_q);
        issue_tag.tlast = (state == ISSUE) && beat_last;
        issue_tag.tuser = (state == FLUSH) || frame[0];
    end

    assign mem_rd_en   = issue && !issue_tag.zero;
    assign mem_rd_addr = mem_rd_en ? (base_q + ADDR_W'(img) * ADDR_W'(WPI) + ADDR_W'(beat)) : '0;

    always_comb begin
        state_n    = state;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (start && (cfg_n_images != '0)) state_n = ISSUE;
            end
            ISSUE: begin
                if (issue && beat_last && seq_last)
                    state_n = (PIPELINE_DELAY == 0) ? DRAIN : FLUSH;
            end
            FLUSH: begin
                if (issue && (flush_cnt == FW'(PIPELINE_DELAY - 1))) state_n = DRAIN;
            end
            DRAIN: begin
                if ((inflight == '0) && fifo_empty) begin
                    drain_done = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) state <= IDLE;
        else               state <= state_n;
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            n_q        <= '0;
            base_q     <= '0;
            old_zero_q <= 1'b0;
            frame      <= '0;
            beat       <= '0;
            flush_cnt  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state == IDLE) && start && (cfg_n_images == '0);
            if ((state == IDLE) && start) begin
                n_q        <= cfg_n_images;
                base_q     <= cfg_base_addr;
                old_zero_q <= cfg_old_zero;
                frame      <= '0;
                beat       <= '0;
                flush_cnt  <= '0;
            end else if (issue && (state == ISSUE)) begin
                if (beat_last) begin
                    beat  <= '0;
                    frame <= frame + 1'b1;
                end else begin
                    beat <= beat + 1'b1;
                end
            end else if (issue && (state == FLUSH)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // Tags travel beside the read so zero beats keep their slot in issue order.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_tag[i] <= '0;
            end
            inflight <= '0;
        end else begin
            pipe_v[0]   <= issue;
            pipe_tag[0] <= issue_tag;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
            inflight <= inflight + IW'(issue) - IW'(pipe_v[MEM_LATENCY-1]);
        end
    end

    assign fifo_din = {pipe_tag[MEM_LATENCY-1].tlast,
                       pipe_tag[MEM_LATENCY-1].tuser,
                       pipe_tag[MEM_LATENCY-1].zero ? WORD_W'(0) : mem_rd_data};

    lrf_sync_fifo #(
        .WIDTH (WORD_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (s_axis_aclk),
        .rst   (s_axis_areset),
        .push  (pipe_v[MEM_LATENCY-1]),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef LRF_SEQ_THROTTLE_EN
    logic [15:0] lfsr;
    logic        hold;

    // tvalid may only rise on lfsr[0]; once raised it is held until accepted.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            lfsr <= LFSR_SEED;
            hold <= 1'b0;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            hold <= m_axis_tvalid && !m_axis_tready;
        end
    end

    assign m_axis_tvalid = !fifo_empty && (hold || lfsr[0]);
`else
    assign m_axis_tvalid = !fifo_empty;
`endif

    assign pop = m_axis_tvalid && m_axis_tready;
    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = m_axis_tvalid ? fifo_dout : '0;

    assign busy = (state != IDLE);
    assign done = done_q || drain_done;

endmodule

// File: tb/tb_lrf_frame_sequencer.sv
// Scoreboard bench for lrf_frame_sequencer: a frame-level model fills an expected
// beat queue; a negedge monitor checks every handshake, stall stability and done timing.
module tb_lrf_frame_sequencer;

    localparam int unsigned PPB  = 16;
    localparam int unsigned PXW  = 8;
    localparam int unsigned DIM  = 8;
    localparam int unsigned MAXI = 64;
    localparam int unsigned NFC  = 1;
    localparam int unsigned PD   = 10;
    localparam int unsigned ML   = 2;
    localparam int unsigned FD   = 8;
    localparam int unsigned AW   = 32;
    localparam int unsigned WW   = PPB * PXW;
    localparam int unsigned WPI  = DIM * DIM / PPB;
    localparam int unsigned H    = 1 << NFC;
    localparam int unsigned NW   = $clog2(MAXI + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NW-1:0] cfg_n = '0;
    logic [AW-1:0] cfg_base = '0;
    logic          cfg_oz = 1'b0;
    logic          busy, done, mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [WW-1:0] mem_rd_data;
    logic [WW-1:0] tdata;
    logic          tvalid, tlast, tuser;
    logic          tready = 1'b0;

    lrf_frame_sequencer #(
        .PIXELS_PER_BEAT (PPB),
        .PIXEL_WIDTH     (PXW),
        .IMAGE_DIM       (DIM),
        .MAX_IMAGES      (MAXI),
        .N_FUSE_COUNT    (NFC),
        .PIPELINE_DELAY  (PD),
        .MEM_LATENCY     (ML),
        .FIFO_DEPTH      (FD),
        .ADDR_W          (AW)
    ) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .start         (start),
        .cfg_n_images  (cfg_n),
        .cfg_base_addr (cfg_base),
        .cfg_old_zero  (cfg_oz),
        .busy          (busy),
        .done          (done),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] data;
        logic          last;
        logic          user;
        bit            fin;
    } beat_t;

    beat_t       exp_q[$];
    longint      done_exp[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    longint      cyc = 0;
    longint      last_done_cyc = 0;
    int unsigned popped = 0;
    int unsigned reads = 0;
    int unsigned dones = 0;
    int unsigned rmode = 3;

    function automatic logic [WW-1:0] word_of(input logic [AW-1:0] a);
        logic [WW-1:0] w;
        w = '0;
        w[31:0]   = a;
        w[63:32]  = a ^ 32'h5A5A_5A5A;
        w[95:64]  = ~a;
        w[127:96] = a * 32'd3;
        return w;
    endfunction

    task automatic chk(input string name, input logic [WW-1:0] got, input logic [WW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Word memory with a fixed two-cycle read latency; junk when not read.
    logic [WW-1:0] m1, m2;
    always @(posedge clk) begin
        m1 <= mem_rd_en ? word_of(mem_rd_addr) : {4{32'hDEAD_BEEF}};
        m2 <= m1;
    end
    assign mem_rd_data = m2;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && mem_rd_en) reads <= reads + 1;
    end

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       tready = 1'b1;
            1:       tready = ~tready;
            2:       tready = 1'($urandom_range(0, 1));
            default: tready = 1'b0;
        endcase
    end

    logic [WW-1:0] prev_data;
    logic          prev_last, prev_user;
    bit            prev_stall = 0;

    always @(negedge clk) begin
        beat_t e;
        bit    exp_d;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("valid_hold", WW'(tvalid), WW'(1));
                chk("data_hold", tdata, prev_data);
                chk("flags_hold", WW'({tlast, tuser}), WW'({prev_last, prev_user}));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", WW'(1), WW'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", tdata, e.data);
                    chk("tlast", WW'(tlast), WW'(e.last));
                    chk("tuser", WW'(tuser), WW'(e.user));
                    if (e.fin) done_exp.push_back(cyc + 1);
                end
                popped++;
            end
            while (done_exp.size() > 0 && done_exp[0] < cyc) begin
                void'(done_exp.pop_front());
                chk("done_missing", WW'(0), WW'(1));
            end
            exp_d = (done_exp.size() > 0 && done_exp[0] == cyc);
            if (exp_d) void'(done_exp.pop_front());
            if (done || exp_d) chk("done", WW'(done), WW'(exp_d));
            if (done) begin
                dones++;
                last_done_cyc = cyc;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            prev_user  = tuser;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level reference: interleaved NEW/OLD frames then zero flush beats.
    function automatic int unsigned push_model(input int unsigned n, input logic [AW-1:0] base,
                                               input bit oz);
        int unsigned nz = 0;
        for (int unsigned p = 0; p < 2 * n; p++) begin
            int unsigned kk   = p / 2;
            int unsigned src  = (p % 2 == 0) ? kk : ((kk >= H) ? kk - H : 0);
            bit          zero = (p % 2 == 1) && (kk < H) && oz;
            for (int unsigned b = 0; b < WPI; b++) begin
                beat_t e;
                e.data = zero ? '0 : word_of(base + AW'(src * WPI + b));
                e.last = (b == WPI - 1);
                e.user = (p % 2 == 1);
                e.fin  = 0;
                if (!zero) nz++;
                exp_q.push_back(e);
            end
        end
        for (int unsigned f = 0; f < PD; f++) begin
            beat_t e;
            e.data = '0;
            e.last = 0;
            e.user = 1;
            e.fin  = (f == PD - 1);
            exp_q.push_back(e);
        end
        return nz;
    endfunction

    task automatic run_seq(input int unsigned n, input logic [AW-1:0] base, input bit oz,
                           input int unsigned mode, input bit stall, input bit poke);
        int unsigned r0, d0, nz;
        longint      c0;
        nz = push_model(n, base, oz);
        rmode = stall ? 3 : mode;
        tick();
        r0 = reads;
        d0 = dones;
        c0 = cyc;
        cfg_n = NW'(n);
        cfg_base = base;
        cfg_oz = oz;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start", WW'(busy), WW'(1));
        if (stall) begin
            repeat (20) tick();
            chk("stall_reads", WW'(reads - r0), WW'(FD));
            chk("stall_valid", WW'(tvalid), WW'(1));
            rmode = mode;
        end
        if (poke) begin
            repeat (3) tick();
            cfg_n = NW'(1);
            cfg_base = $urandom;
            cfg_oz = ~oz;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int i = 0; i < 4000 && dones == d0; i++) tick();
        if (dones == d0) chk("seq_timeout", WW'(0), WW'(1));
        tick();
        chk("reads", WW'(reads - r0), WW'(nz));
        chk("busy_end", WW'(busy), WW'(0));
        chk("queue_empty", WW'(exp_q.size()), WW'(0));
`ifndef LRF_SEQ_THROTTLE_EN
        if (mode == 0 && !stall && !poke)
            chk("throughput", WW'(last_done_cyc - c0 <= longint'(2 * n * WPI + PD + ML + 3)), WW'(1));
`endif
    endtask

    initial begin
        int unsigned p0, d0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", WW'(tvalid), WW'(0));
        chk("rst_busy", WW'(busy), WW'(0));
        chk("rst_done", WW'(done), WW'(0));
        chk("rst_rd_en", WW'(mem_rd_en), WW'(0));
        rst = 1'b0;
        tick();

        run_seq(4, 32'h100, 0, 0, 0, 0);
        run_seq(4, 32'h100, 1, 0, 0, 0);
        run_seq(4, 32'h100, 0, 1, 1, 0);
        run_seq(3, 32'h240, 0, 1, 0, 1);

        // n = 0: immediate done, no beats, busy never set
        rmode = 0;
        tick();
        d0 = dones;
        p0 = popped;
        cfg_n = '0;
        start = 1'b1;
        done_exp.push_back(cyc + 1);
        tick();
        start = 1'b0;
        chk("zero_busy", WW'(busy), WW'(0));
        repeat (3) tick();
        chk("zero_done", WW'(dones - d0), WW'(1));
        chk("zero_beats", WW'(popped - p0), WW'(0));

        // reset in the middle of frame 2
        void'(push_model(4, 32'h100, 0));
        d0 = dones;
        p0 = popped;
        cfg_n = NW'(4);
        cfg_base = 32'h100;
        cfg_oz = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && popped < p0 + 2 * WPI + 2; i++) tick();
        chk("reset_reach", WW'(popped >= p0 + 2 * WPI + 2), WW'(1));
        rst = 1'b1;
        rmode = 3;
        exp_q.delete();
        done_exp.delete();
        tick();
        rst = 1'b0;
        chk("abort_tvalid", WW'(tvalid), WW'(0));
        chk("abort_busy", WW'(busy), WW'(0));
        repeat (10) tick();
        chk("abort_no_done", WW'(dones - d0), WW'(0));
        run_seq(4, 32'h100, 0, 0, 0, 0);

        // randomized sequences, including address wrap
        run_seq(2, 32'hFFFF_FFF8, 0, 2, 0, 0);
        for (int t = 0; t < 6; t++)
            run_seq($urandom_range(1, 5), $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lrf_frame_sequencer.md
Name: lrf_frame_sequencer

Overview:
- Synthesizable AXI4-Stream frame source for the LRF fusion core. Replaces the bench-only input controller.
- Reads stored frames from a fixed-latency word memory and emits interleaved NEW/OLD frame pairs, then PIPELINE_DELAY zero flush beats.
- Sits between the DDR/BRAM reader and the LRF s_axis port.
- Generalises the bench: runtime image count, base address, OLD-frame mode, configurable memory latency with prefetch FIFO.

Parameters:
PIXELS_PER_BEAT, 16, pixels per AXI beat
PIXEL_WIDTH, 8, bits per pixel; WORD_W = PIXELS_PER_BEAT*PIXEL_WIDTH
IMAGE_DIM, 512, square image side; WPI = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT words per image
MAX_IMAGES, 64, upper bound on cfg_n_images
N_FUSE_COUNT, 4, history distance H = 1<<N_FUSE_COUNT images
PIPELINE_DELAY, 10, zero flush beats after the last frame
MEM_LATENCY, 2, cycles from mem_rd_en to mem_rd_data valid (>=1)
FIFO_DEPTH, 8, prefetch FIFO depth, power of 2, >= MEM_LATENCY+2
ADDR_W, 32, memory word-address width

Ports:
s_axis_aclk  in  1  clock
s_axis_areset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, begins a sequence when idle
cfg_n_images  in  $clog2(MAX_IMAGES+1)  images to process, sampled at start
cfg_base_addr  in  ADDR_W  word address of image 0, sampled at start
cfg_old_zero  in  1  1: OLD frame is all-zero when k<H; 0: use image 0 (sampled at start)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last flush beat handshakes
mem_rd_en  out  1  read request
mem_rd_addr  out  ADDR_W  read word address
mem_rd_data  in  WORD_W  read data, valid MEM_LATENCY cycles after mem_rd_en
m_axis_tdata  out  WORD_W  beat data
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat of each frame (never on flush beats)
m_axis_tuser  out  1  0 = NEW frame beat, 1 = OLD frame or flush beat

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO, credit counter and latency pipe cleared. Reset mid-sequence aborts it, with no done pulse.
- FSM states:
  - IDLE: start with cfg_n_images>0 -> ISSUE, busy=1. start with cfg_n_images==0 -> done pulse next cycle, stays IDLE. start while busy is ignored.
  - ISSUE: issues frames p = 0..2*n-1, beats b = 0..WPI-1.
    - Even p: NEW image k=p/2, addr = base + k*WPI + b.
    - Odd p: OLD image. k>=H -> image k-H; k<H -> image 0 (cfg_old_zero=0) or zero beat with no mem read (cfg_old_zero=1).
    - tlast tag when b==WPI-1.
    - After the last beat -> FLUSH.
  - FLUSH: issues PIPELINE_DELAY zero beats (tuser=1, tlast=0) -> DRAIN.
  - DRAIN: waits for FIFO empty and last handshake; pulses done, clears busy -> IDLE.
- Issue rule: one beat may issue per cycle only when inflight + fifo_count < FIFO_DEPTH (credit-based), so the FIFO never overflows.
- Zero beats travel the same MEM_LATENCY tag pipe with mem_rd_en=0 and data forced 0. Output order equals issue order.
- Tags (tlast, tuser, zero) ride a MEM_LATENCY-deep shift register alongside the read.
- Output:
  - m_axis_tvalid = FIFO non-empty.
  - Pop on tvalid&tready.
  - tdata/tlast/tuser are stable while tvalid && !tready.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Throughput: 1 beat/cycle sustained with tready=1 once MEM_LATENCY+1 cycles of fill have elapsed.
- Address arithmetic is modulo 2^ADDR_W.

Optional Feature:
LRF_SEQ_THROTTLE_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, reset to seed) advances each cycle. tvalid may only rise in a cycle where lfsr[0]=1. Once high, tvalid holds until handshake, as AXI requires.
- Undefined: no LFSR; tvalid = FIFO non-empty.

Decomposition:
- lrf_pkg holds:
  - FSM state enum (IDLE, ISSUE, FLUSH, DRAIN)
  - tag struct {zero, tlast, tuser}
  - $clog2-derived width constants
- Sub-module lrf_sync_fifo: parametrised WIDTH/DEPTH synchronous FIFO with count output, first-word-fall-through.

Test Plan:
- Default config base IMAGE_DIM=8, PPB=16 (WPI=4), N_FUSE_COUNT=1 (H=2), MEM_LATENCY=2, tready=1.
- n=4, old_zero=0, base=0x100, memory word = its address -> image order N0,O0,N1,O0,N2,O0,N3,O1 (addr 0x100,0x100,0x104,0x100,0x108,0x100,0x10C,0x104 first beats). Then 32 beats with tlast every 4th, 10 zero beats, done one cycle after last handshake.
- Same as above with old_zero=1 -> OLD frames for k=0,1 are all-zero with no mem_rd_en during them. O0 for k=2 reads 0x100.
- tready toggling 1-0-1 each cycle and tready held 0 for 20 cycles -> no mem_rd_en once credits = 8. No lost, duplicated or reordered beats; tdata stable while stalled.
- Assert reset mid-frame 2 beat 1 -> next cycle tvalid=0, busy=0, no done. A new start replays from N0.
- start with cfg_n_images=0 -> done pulse, no beats. start while busy -> ignored, sequence unchanged.
- With LRF_SEQ_THROTTLE_EN: same data stream as test 1; tvalid never drops without a handshake; total beats = 42.
